prom_load_ctrl: RTL
===================

Name: prom_load_ctrl

Overview:
Sequences program loading into the instruction PROM from the UART byte stream, replacing free-running byte-pair capture with a framed, checked load.
- Frame: sync byte, word count, N little-endian 16-bit words, 8-bit checksum.
- Drives the PROM write port and holds the CPU in reset until a frame passes its checksum.
- Sits between the UART receiver and the PROM write port in the top level.

Parameters:
ROM_WORDS, 64, PROM depth in words; power of 2, at least 2
TIMEOUT_TICKS, 6250, idle clk cycles allowed between frame bytes before the frame is aborted
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data_i  input  8  received UART byte
rx_ready_i  input  1  rx_data_i valid
rx_ack_o  output  1  byte consumed this cycle
prom_addr_o  output  $clog2(ROM_WORDS)  PROM write address
prom_data_o  output  16  PROM write data
prom_we_o  output  1  PROM write strobe
cpu_reset_o  output  1  CPU held in reset while high
done_o  output  1  valid program loaded
error_o  output  1  last frame aborted

Behaviour:
- Clocking: one clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - prom_we_o=0, prom_addr_o=0, prom_data_o=0
  - cpu_reset_o=1, done_o=0, error_o=0
  - rx_ack_o=0 (forced low while reset is high)
  - state=IDLE
- States: IDLE, COUNT, LOW, HIGH, WRITE, CHECK, DONE, ERROR.
- Byte acceptance:
  - A byte is accepted in a cycle where rx_ready_i=1 and state is not WRITE.
  - rx_ack_o = rx_ready_i & (state != WRITE), combinational.
  - In WRITE, the pending byte is held and accepted next cycle.
- IDLE:
  - Bytes other than SYNC_BYTE are accepted and discarded.
  - SYNC_BYTE -> COUNT; clears word index, checksum accumulator and timeout counter.
- COUNT:
  - Byte n with 1 <= n <= ROM_WORDS -> store N=n, sum=n, go to LOW.
  - n=0 or n>ROM_WORDS -> ERROR.
- LOW: prom_data_o[7:0]<=byte, sum+=byte -> HIGH.
- HIGH: prom_data_o[15:8]<=byte, sum+=byte -> WRITE.
- WRITE (exactly one cycle):
  - prom_we_o=1, prom_addr_o=index.
  - If index==N-1 -> CHECK; else index+1 -> LOW.
  - prom_we_o is registered: high only during the WRITE cycle.
- CHECK:
  - If (sum+byte) mod 256 == 0 -> DONE; else -> ERROR.
  - Sum is 8-bit, wrap-around.
- DONE:
  - done_o=1, cpu_reset_o=0, error_o=0, registered.
  - These take effect the cycle after the checksum byte is accepted.
  - All bytes are accepted and ignored. Without the optional feature, DONE is left only by reset.
- ERROR:
  - error_o=1, cpu_reset_o=1, done_o=0.
  - Non-sync bytes are discarded. SYNC_BYTE -> COUNT and clears error_o.
- cpu_reset_o=1 in every state except DONE. It re-asserts immediately on reset.
- PROM words written before a failed checksum remain in the PROM, but the CPU is never released on them.
- Timeout:
  - Counter runs in COUNT/LOW/HIGH/WRITE/CHECK and clears on each accepted byte.
  - If TIMEOUT_TICKS consecutive cycles pass with no accepted byte -> ERROR.
  - A byte arriving in the final cycle is accepted; no timeout.
  - No timeout in IDLE/DONE/ERROR.
- Reset mid-frame: returns to IDLE with reset values. Partially written PROM contents are left as-is.
- prom_addr_o never wraps, because N <= ROM_WORDS.

Optional Feature:
PROM_LOAD_RELOAD_EN
- Defined: in DONE, SYNC_BYTE -> COUNT. On the next cycle cpu_reset_o=1 and done_o=0, so a new program can be loaded without a board reset. Other bytes in DONE are ignored.
- Undefined: DONE is terminal until reset; SYNC_BYTE in DONE is discarded.

Test Plan:
- Nominal load, bytes A5 02 34 12 CD AB 40 -> writes addr0=0x1234 and addr1=0xABCD, each prom_we_o one cycle; done_o=1 and cpu_reset_o=0 one cycle after 0x40 is accepted.
- Bad checksum, same frame ending 0x41 -> error_o=1, cpu_reset_o=1, done_o=0; then a full valid frame -> done_o=1, error_o=0.
- Count bounds, A5 00 and A5 41 with ROM_WORDS=64 -> error_o=1 with no prom_we_o; A5 40 followed by 128 bytes and a correct checksum -> 64 writes to addr0..63, done_o=1.
- Leading garbage and hold-off: 00 FF 5A then a valid frame -> garbage ignored, load succeeds; rx_ready_i held high across WRITE -> rx_ack_o=0 in WRITE, no byte lost.
- Timeout: A5 02 34, then silence -> error_o=1 exactly TIMEOUT_TICKS cycles after 0x34 was accepted; a byte arriving one cycle earlier -> no error.
- Reset and reload: reset asserted after A5 02 34 12 -> IDLE, cpu_reset_o=1. With PROM_LOAD_RELOAD_EN, sending A5 in DONE -> cpu_reset_o=1 next cycle; without it -> stays in DONE.

Source files
------------

// File: rtl/prom_load_ctrl.sv
// Framed PROM loader: SYNC, count, N little-endian words, 8-bit checksum; holds the CPU in reset until a frame checks out.
// Optional macro PROM_LOAD_RELOAD_EN: a SYNC byte received in DONE starts a new load without a board reset.
module prom_load_ctrl #(
  parameter int          ROM_WORDS     = 64,
  parameter int          TIMEOUT_TICKS = 6250,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_ready_i,
  output logic                         rx_ack_o,
  output logic [$clog2(ROM_WORDS)-1:0] prom_addr_o,
  output logic [15:0]                  prom_data_o,
  output logic                         prom_we_o,
  output logic                         cpu_reset_o,
  output logic                         done_o,
  output logic                         error_o
);
  localparam int AW = $clog2(ROM_WORDS);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {IDLE, COUNT, LOW, HIGH, WRITE, CHECK, DONE, ERROR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, last_q, last_d;
  logic [7:0]    sum_q, sum_d;
  logic [15:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, cpu_rst_q, done_q, err_q;
  logic          accept, timed;

  // WRITE stalls the byte stream so the pending byte waits one cycle.
  assign rx_ack_o = rx_ready_i & ~reset & (state_q != WRITE);
  assign accept   = rx_ack_o;
  assign timed    = (state_q == COUNT) || (state_q == LOW) || (state_q == HIGH) ||
                    (state_q == WRITE) || (state_q == CHECK);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sum_d   = sum_q;
    data_d  = data_q;
    tmo_d   = '0;
    if (timed && !accept) tmo_d = tmo_q + 1'b1;
    case (state_q)
      IDLE, ERROR: begin
        if (accept && rx_data_i == SYNC_BYTE) begin
          state_d = COUNT;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      COUNT: begin
        if (accept) begin
          if (rx_data_i != 8'd0 && int'(rx_data_i) <= ROM_WORDS) begin
            last_d  = AW'(rx_data_i - 8'd1);
            sum_d   = rx_data_i;
            state_d = LOW;
          end else begin
            state_d = ERROR;
          end
        end
      end
      LOW: begin
        if (accept) begin
          data_d[7:0] = rx_data_i;
          sum_d       = sum_q + rx_data_i;
          state_d     = HIGH;
        end
      end
      HIGH: begin
        if (accept) begin
          data_d[15:8] = rx_data_i;
          sum_d        = sum_q + rx_data_i;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        if (idx_q == last_q) begin
          state_d = CHECK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOW;
        end
      end
      CHECK: begin
        if (accept) state_d = (8'(sum_q + rx_data_i) == 8'd0) ? DONE : ERROR;
      end
      DONE: begin
`ifdef PROM_LOAD_RELOAD_EN
        if (accept && rx_data_i == SYNC_BYTE) begin
          state_d = COUNT;
          idx_d   = '0;
          sum_d   = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // A byte accepted in the final cycle wins over the timeout.
    if (timed && !accept && tmo_q == TW'(TIMEOUT_TICKS - 1)) state_d = ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      sum_q     <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      we_q      <= (state_d == WRITE);
      cpu_rst_q <= (state_d != DONE);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERROR);
    end
  end

  assign prom_addr_o = idx_q;
  assign prom_data_o = data_q;
  assign prom_we_o   = we_q;
  assign cpu_reset_o = cpu_rst_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
endmodule
